// File: rtl/wb_retire.sv
`default_nettype none
// ============================================================================
//  Module   : wb_retire
//  Purpose  : Writeback/retire stage between the MEM/WB register and the
//             register file. Registers the regfile write port, drops x0
//             writes, counts cycles and retired instructions, and runs an
//             exit FSM (RUN -> DRAIN -> HALT) that reports good/bad trap.
//  Options  : WB_TRACE_EN - per-instruction retire trace (simulation only)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_retire #(
    parameter int XLEN           = 64,
    parameter int RF_AW          = 5,
    parameter int CNT_W          = 64,
    parameter int DRAIN_CYCLES   = 2,
    parameter int FINISH_ON_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             rf_wen_i,
    input  logic [RF_AW-1:0] rf_rd_i,
    input  logic [XLEN-1:0]  rf_wdata_i,
    input  logic             exit_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  a0_i,
    output logic             rf_wen_o,
    output logic [RF_AW-1:0] rf_rd_o,
    output logic [XLEN-1:0]  rf_wdata_o,
    output logic             halted_o,
    output logic             good_trap_o,
    output logic [XLEN-1:0]  exit_code_o,
    output logic [XLEN-1:0]  exit_pc_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);

    // Drain counter must hold DRAIN_CYCLES; +2 keeps the width >= 1 for 0.
    localparam int              c_DW       = $clog2(DRAIN_CYCLES + 2);
    localparam logic [c_DW-1:0] c_DRAIN_LD = c_DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_DW-1:0] r_drain_cnt;
    logic [c_DW-1:0] w_drain_cnt_nxt;
    logic            w_accept;
    logic            w_exit;

    assign ready_o     = (r_state == S_RUN);
    assign w_accept    = valid_i & ready_o;
    assign w_exit      = w_accept & exit_i;
    assign halted_o    = (r_state == S_HALT);
    assign good_trap_o = halted_o & (exit_code_o == '0);

    // Exit FSM next-state: drain for DRAIN_CYCLES cycles after the exit accept.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            S_RUN: begin
                if (w_exit) begin
                    w_drain_cnt_nxt = c_DRAIN_LD;
                    w_state_nxt     = (DRAIN_CYCLES == 0) ? S_HALT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_drain_cnt_nxt = r_drain_cnt - c_DW'(1);
                if (r_drain_cnt <= c_DW'(1)) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // State, write port, exit latches and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
            rf_wen_o    <= 1'b0;
            rf_rd_o     <= '0;
            rf_wdata_o  <= '0;
            exit_code_o <= '0;
            exit_pc_o   <= '0;
            cycle_o     <= '0;
            instret_o   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            rf_wen_o    <= w_accept & rf_wen_i & (rf_rd_i != '0);
            if (w_accept) begin
                rf_rd_o    <= rf_rd_i;
                rf_wdata_o <= rf_wdata_i;
                instret_o  <= instret_o + CNT_W'(1);
            end
            if (w_exit) begin
                exit_pc_o   <= pc_i;
                exit_code_o <= a0_i;
            end
            if (r_state != S_HALT) begin
                cycle_o <= cycle_o + CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    logic r_msg_done;

    // One-shot trap report once the FSM sits in HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg_done <= 1'b0;
        end else if (halted_o && !r_msg_done) begin
            r_msg_done <= 1'b1;
            if (exit_code_o == '0) begin
                $display("hit good trap at pc = %h", exit_pc_o);
            end else begin
                $display("hit bad trap at pc = %h", exit_pc_o);
            end
            $display("exit value = %h", exit_code_o);
            if (FINISH_ON_EXIT != 0) begin
                $finish;
            end
        end
    end
`endif

`ifdef WB_TRACE_EN
    // Retire trace: one line per accepted instruction.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            if (rf_wen_i && (rf_rd_i != '0)) begin
                $display("[%0d] pc=%h rd=%0d wdata=%h%s", cycle_o, pc_i,
                         rf_rd_i, rf_wdata_i, exit_i ? " EXIT" : "");
            end else begin
                $display("[%0d] pc=%h --%s", cycle_o, pc_i,
                         exit_i ? " EXIT" : "");
            end
        end
    end
`else
    // Trace disabled: no extra logic.
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_retire.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_retire
//  Purpose  : Self-checking bench for wb_retire. Two instances share inputs:
//             u_dut (CNT_W=64, DRAIN_CYCLES=2) and u_dut2 (CNT_W=4,
//             DRAIN_CYCLES=0). A transaction-level model predicts outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_retire;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, rf_wen_i, exit_i;
    logic [4:0]  rf_rd_i;
    logic [63:0] rf_wdata_i, pc_i, a0_i;

    logic        ready1, wen1, halted1, good1;
    logic [4:0]  rd1;
    logic [63:0] wdata1, code1, epc1, cyc1, ins1;

    logic        ready2, wen2, halted2, good2;
    logic [4:0]  rd2;
    logic [63:0] wdata2, code2, epc2;
    logic [3:0]  cyc2, ins2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_retire #(.XLEN(64), .RF_AW(5), .CNT_W(64), .DRAIN_CYCLES(2),
                .FINISH_ON_EXIT(0)) u_dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready1),
        .rf_wen_i(rf_wen_i), .rf_rd_i(rf_rd_i), .rf_wdata_i(rf_wdata_i),
        .exit_i(exit_i), .pc_i(pc_i), .a0_i(a0_i),
        .rf_wen_o(wen1), .rf_rd_o(rd1), .rf_wdata_o(wdata1),
        .halted_o(halted1), .good_trap_o(good1), .exit_code_o(code1),
        .exit_pc_o(epc1), .cycle_o(cyc1), .instret_o(ins1));

    wb_retire #(.XLEN(64), .RF_AW(5), .CNT_W(4), .DRAIN_CYCLES(0),
                .FINISH_ON_EXIT(0)) u_dut2 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready2),
        .rf_wen_i(rf_wen_i), .rf_rd_i(rf_rd_i), .rf_wdata_i(rf_wdata_i),
        .exit_i(exit_i), .pc_i(pc_i), .a0_i(a0_i),
        .rf_wen_o(wen2), .rf_rd_o(rd2), .rf_wdata_o(wdata2),
        .halted_o(halted2), .good_trap_o(good2), .exit_code_o(code2),
        .exit_pc_o(epc2), .cycle_o(cyc2), .instret_o(ins2));

    // Reference model: one entry per instance, updated once per clock edge.
    longint unsigned m_cycle[2], m_instret[2], m_pc[2], m_code[2], m_wdata[2];
    int              m_rd[2], m_after[2];
    bit              m_wen[2], m_exited[2];

    function automatic int drn(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic bit m_halted(int k);
        return m_exited[k] && (m_after[k] >= drn(k));
    endfunction

    task automatic model_edge(bit r, bit v, bit we, int rd, longint unsigned wd,
                              bit ex, longint unsigned pc, longint unsigned a0);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_cycle[k] = 0; m_instret[k] = 0; m_pc[k] = 0; m_code[k] = 0;
                m_wdata[k] = 0; m_rd[k] = 0; m_after[k] = 0;
                m_wen[k] = 0; m_exited[k] = 0;
            end else begin
                bit acc;
                acc = v && !m_exited[k];
                if (!m_halted(k)) m_cycle[k]++;
                if (acc) m_instret[k]++;
                m_wen[k] = acc && we && (rd != 0);
                if (acc) begin
                    m_rd[k] = rd;
                    m_wdata[k] = wd;
                end
                if (m_exited[k] && m_after[k] < 1000) m_after[k]++;
                if (acc && ex) begin
                    m_exited[k] = 1; m_after[k] = 0; m_pc[k] = pc; m_code[k] = a0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready",     {63'b0, ready1},  {63'b0, !m_exited[0]});
        chk("wen",       {63'b0, wen1},    {63'b0, m_wen[0]});
        chk("rd",        {59'b0, rd1},     64'(m_rd[0]));
        chk("wdata",     wdata1,           m_wdata[0]);
        chk("halted",    {63'b0, halted1}, {63'b0, m_halted(0)});
        chk("good",      {63'b0, good1},   {63'b0, m_halted(0) && m_code[0] == 0});
        chk("exit_code", code1,            m_code[0]);
        chk("exit_pc",   epc1,             m_pc[0]);
        chk("cycle",     cyc1,             m_cycle[0]);
        chk("instret",   ins1,             m_instret[0]);
        chk("ready2",    {63'b0, ready2},  {63'b0, !m_exited[1]});
        chk("wen2",      {63'b0, wen2},    {63'b0, m_wen[1]});
        chk("halted2",   {63'b0, halted2}, {63'b0, m_halted(1)});
        chk("good2",     {63'b0, good2},   {63'b0, m_halted(1) && m_code[1] == 0});
        chk("exit_pc2",  epc2,             m_pc[1]);
        chk("cycle2",    {60'b0, cyc2},    m_cycle[1] & 64'hF);
        chk("instret2",  {60'b0, ins2},    m_instret[1] & 64'hF);
    endtask

    task automatic step(bit r, bit v, bit we, int rd, longint unsigned wd,
                        bit ex, longint unsigned pc, longint unsigned a0);
        rst = r; valid_i = v; rf_wen_i = we; rf_rd_i = 5'(rd);
        rf_wdata_i = wd; exit_i = ex; pc_i = pc; a0_i = a0;
        @(posedge clk);
        model_edge(r, v, we, rd, wd, ex, pc, a0);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        do_reset();

        // Three writes, the last one to x0
        step(0, 1, 1, 1, 64'h11, 0, 64'h1000, 0);
        step(0, 1, 1, 2, 64'h22, 0, 64'h1004, 0);
        step(0, 1, 1, 0, 64'h33, 0, 64'h1008, 0);
        idle();
        chk("instret_after_3", ins1, 64'd3);

        // Non-writing instructions, then bubbles
        for (int i = 0; i < 4; i++) step(0, 1, 0, 5, 64'hDEAD, 0, 64'h2000 + 64'(4*i), 0);
        idle();
        idle();

        // Random traffic; exit_i only ever with valid_i low (must be ignored)
        for (int i = 0; i < 40; i++) begin
            bit v;
            v = 1'($urandom_range(0, 1));
            step(0, v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 {32'($urandom), 32'($urandom)}, !v && ($urandom_range(0, 3) == 0),
                 64'h3000 + 64'(4*i), 64'($urandom));
        end

        // Good trap: exit at 0x80000010 with a0=0, traffic keeps arriving
        step(0, 1, 0, 0, 0, 1, 64'h80000010, 64'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 3, 64'h77, 0, 64'h80000014, 0);
        chk("good_trap_pc", epc1, 64'h80000010);

        // Bad trap with a write on the exit instruction itself
        do_reset();
        step(0, 1, 1, 4, 64'h44, 0, 64'h100, 0);
        step(0, 1, 1, 10, 64'hABC, 1, 64'h104, 64'h5);
        for (int i = 0; i < 6; i++) step(0, i[0], 1, 6, 64'h66, 0, 64'h108, 0);
        chk("bad_trap_code", code1, 64'h5);

        // Reset in the middle of DRAIN
        do_reset();
        step(0, 1, 1, 7, 64'h70, 0, 64'h200, 0);
        step(0, 1, 0, 0, 0, 1, 64'h204, 64'h9);
        step(0, 1, 1, 8, 64'h80, 0, 64'h208, 0);
        step(1, 1, 1, 8, 64'h80, 0, 64'h208, 0);
        chk("ready_after_drain_rst", {63'b0, ready1}, 64'd1);
        idle();

        // 4-bit counter wrap: 17 accepts from reset
        do_reset();
        for (int i = 0; i < 17; i++)
            step(0, 1, 1, int'($urandom_range(0, 31)), 64'($urandom), 0, 64'h400 + 64'(4*i), 0);
        chk("instret2_wrap", {60'b0, ins2}, 64'd1);
        chk("instret_17", ins1, 64'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
